// File: rtl/expr_pkg.sv
// Shared types and character codes for the serial expression recogniser.
package expr_pkg;

    typedef enum logic [1:0] {
        S_START,
        S_NUM,
        S_OP,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        CLS_DIGIT,
        CLS_OP,
        CLS_IDLE,
        CLS_OTHER
    } cls_t;

    localparam logic [7:0] CHR_DIGIT_LO = 8'h30;
    localparam logic [7:0] CHR_DIGIT_HI = 8'h39;
    localparam logic [7:0] CHR_OP_ADD   = 8'h2B;
    localparam logic [7:0] CHR_OP_MUL   = 8'h2A;
    localparam logic [7:0] CHR_IDLE     = 8'h00;

endpackage

// File: rtl/expr_fsm_if.sv
// Character stream into the recogniser and its valid-expression flag back out.
interface expr_fsm_if;

    logic [7:0] in;
    logic       out;

    modport master (output in, input out);
    modport slave  (input in, output out);

endinterface

// File: rtl/expr_char_class.sv
// Combinational classifier: ASCII byte -> digit / operator / idle / other.
module expr_char_class
    import expr_pkg::*;
#(
    parameter logic [7:0] DIGIT_LO = CHR_DIGIT_LO,
    parameter logic [7:0] DIGIT_HI = CHR_DIGIT_HI,
    parameter logic [7:0] OP_ADD   = CHR_OP_ADD,
    parameter logic [7:0] OP_MUL   = CHR_OP_MUL,
    parameter logic [7:0] IDLE_CHR = CHR_IDLE
) (
    input  logic [7:0] in,
    output cls_t       cls
);

    always_comb begin
        cls = CLS_OTHER;
        if ((in >= DIGIT_LO) && (in <= DIGIT_HI)) begin
            cls = CLS_DIGIT;
        end else if ((in == OP_ADD) || (in == OP_MUL)) begin
            cls = CLS_OP;
        end else if (in == IDLE_CHR) begin
            cls = CLS_IDLE;
        end
    end

endmodule

// File: rtl/expr_fsm.sv
// Moore recogniser for expressions D(OD)*; out is high while input so far is valid.
// Define EXPR_MULTIDIGIT_EN to accept multi-digit operands.
module expr_fsm
    import expr_pkg::*;
#(
    parameter logic [7:0] DIGIT_LO = CHR_DIGIT_LO,
    parameter logic [7:0] DIGIT_HI = CHR_DIGIT_HI,
    parameter logic [7:0] OP_ADD   = CHR_OP_ADD,
    parameter logic [7:0] OP_MUL   = CHR_OP_MUL,
    parameter logic [7:0] IDLE_CHR = CHR_IDLE
) (
    input  logic       clk,
    input  logic       clr,
    expr_fsm_if.slave  bus
);

    cls_t   cls;
    state_t state;

    expr_char_class #(
        .DIGIT_LO (DIGIT_LO),
        .DIGIT_HI (DIGIT_HI),
        .OP_ADD   (OP_ADD),
        .OP_MUL   (OP_MUL),
        .IDLE_CHR (IDLE_CHR)
    ) u_class (
        .in  (bus.in),
        .cls (cls)
    );

    // Idle bytes leave the state untouched in every state, including S_ERR.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= S_START;
        end else if (cls != CLS_IDLE) begin
            case (state)
                S_START: state <= (cls == CLS_DIGIT) ? S_NUM : S_ERR;
                S_NUM: begin
                    if (cls == CLS_OP) begin
                        state <= S_OP;
                    end else if (cls == CLS_DIGIT) begin
`ifdef EXPR_MULTIDIGIT_EN
                        state <= S_NUM;
`else
                        state <= S_ERR;
`endif
                    end else begin
                        state <= S_ERR;
                    end
                end
                S_OP:    state <= (cls == CLS_DIGIT) ? S_NUM : S_ERR;
                default: state <= S_ERR;
            endcase
        end
    end

    assign bus.out = (state == S_NUM);

endmodule

// File: tb/tb_expr_fsm.sv
// Table-driven self-checking bench for expr_fsm with a scoreboard queue.
module tb_expr_fsm;

    typedef struct packed {
        logic       rst;
        logic [7:0] ch;
        logic       exp;
    } vec_t;

    logic clk;
    logic clr;
    expr_fsm_if bus();

    expr_fsm dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    logic sb[$];
    vec_t tbl[$];

`ifdef EXPR_MULTIDIGIT_EN
    localparam logic MD = 1'b1;
`else
    localparam logic MD = 1'b0;
`endif

    function automatic vec_t mk(input logic r, input logic [7:0] c, input logic e);
        vec_t v;
        v.rst = r;
        v.ch  = c;
        v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d]: out=%b expected=%b", name, idx, got, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic e;
        @(negedge clk);
        if (v.rst) begin
            clr = 1'b0;
            #1;
            check("reset_pulse", idx, bus.out, 1'b0);
            clr = 1'b1;
        end
        bus.in = v.ch;
        sb.push_back(v.exp);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("vec", idx, bus.out, e);
    endtask

    initial begin
        // '0' '+' '1' '*'
        tbl.push_back(mk(1'b1, "0", 1'b1));
        tbl.push_back(mk(1'b0, "+", 1'b0));
        tbl.push_back(mk(1'b0, "1", 1'b1));
        tbl.push_back(mk(1'b0, "*", 1'b0));
        // '7' '*' '3' then idle x3
        tbl.push_back(mk(1'b1, "7", 1'b1));
        tbl.push_back(mk(1'b0, "*", 1'b0));
        tbl.push_back(mk(1'b0, "3", 1'b1));
        tbl.push_back(mk(1'b0, 8'h00, 1'b1));
        tbl.push_back(mk(1'b0, 8'h00, 1'b1));
        tbl.push_back(mk(1'b0, 8'h00, 1'b1));
        // leading operator is sticky error; reset recovers
        tbl.push_back(mk(1'b1, "+", 1'b0));
        tbl.push_back(mk(1'b0, "5", 1'b0));
        tbl.push_back(mk(1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(1'b1, "5", 1'b1));
        // other character
        tbl.push_back(mk(1'b1, "1", 1'b1));
        tbl.push_back(mk(1'b0, "a", 1'b0));
        tbl.push_back(mk(1'b0, "2", 1'b0));
        // digit after digit
        tbl.push_back(mk(1'b1, "1", 1'b1));
        tbl.push_back(mk(1'b0, "2", MD));
        // class boundaries around digit/op codes
        tbl.push_back(mk(1'b1, "9", 1'b1));
        tbl.push_back(mk(1'b0, "+", 1'b0));
        tbl.push_back(mk(1'b0, "0", 1'b1));
        tbl.push_back(mk(1'b1, ":", 1'b0));
        tbl.push_back(mk(1'b1, "/", 1'b0));
        tbl.push_back(mk(1'b1, "4", 1'b1));
        tbl.push_back(mk(1'b0, ",", 1'b0));
        // double operator
        tbl.push_back(mk(1'b1, "5", 1'b1));
        tbl.push_back(mk(1'b0, "*", 1'b0));
        tbl.push_back(mk(1'b0, "+", 1'b0));
        tbl.push_back(mk(1'b0, "6", 1'b0));
        // idle inside an expression after an operator
        tbl.push_back(mk(1'b1, "2", 1'b1));
        tbl.push_back(mk(1'b0, "+", 1'b0));
        tbl.push_back(mk(1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(1'b0, "8", 1'b1));
`ifdef EXPR_MULTIDIGIT_EN
        // "12+305"
        tbl.push_back(mk(1'b1, "1", 1'b1));
        tbl.push_back(mk(1'b0, "2", 1'b1));
        tbl.push_back(mk(1'b0, "+", 1'b0));
        tbl.push_back(mk(1'b0, "3", 1'b1));
        tbl.push_back(mk(1'b0, "0", 1'b1));
        tbl.push_back(mk(1'b0, "5", 1'b1));
`endif

        // reset with idle input, then two idle clocks
        clr = 1'b0;
        bus.in = 8'h00;
        #1;
        check("reset_async", 0, bus.out, 1'b0);
        @(negedge clk);
        clr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("idle_start", i, bus.out, 1'b0);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // asynchronous clear between edges while out is high
        apply(mk(1'b1, "3", 1'b1), 100);
        @(negedge clk);
        bus.in = 8'h00;
        clr = 1'b0;
        #1;
        check("async_clr", 0, bus.out, 1'b0);
        #2;
        clr = 1'b1;
        @(posedge clk);
        #1;
        check("async_clr_hold", 0, bus.out, 1'b0);
        apply(mk(1'b0, "4", 1'b1), 101);

        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard: leftover=%0d expected=0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
